// File: rtl/sram_arb_ctrl_if.sv
// Requester-side bus of the SRAM arbiter: two request ports plus shared read-return path.
// The master modport is the requester side, the slave modport is the controller side.
interface sram_arb_ctrl_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16
);
  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [1:0]        be_a;
  logic [1:0]        be_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              rvalid_a;
  logic              rvalid_b;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req_a, req_b, we_a, we_b, be_a, be_b, addr_a, addr_b, wdata_a, wdata_b,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, busy
  );

  modport slave (
    input  req_a, req_b, we_a, we_b, be_a, be_b, addr_a, addr_b, wdata_a, wdata_b,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, busy
  );
endinterface

// File: rtl/sram_arb_ctrl.sv
// Round-robin two-port arbiter and access sequencer for an external asynchronous SRAM.
// Every pin and handshake output is a flop loaded from the next-state decode.
module sram_arb_ctrl #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 3,
  parameter int WR_WAIT = 3,
  parameter int TURN    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_arb_ctrl_if.slave    bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ce2,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_HOLD  = 3'd4,
    ST_TURN  = 3'd5
  } state_t;

  localparam logic [3:0] RD_LAST   = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LAST   = 4'(WR_WAIT - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURN - 1);
  localparam logic       TURN_EN   = (TURN != 0);

  state_t            state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic              last_b_r, last_b_nxt_s;
  logic              port_b_r, port_b_nxt_s;
  logic              we_r, we_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [DATA_W-1:0] dq_o_r, dq_o_nxt_s;
  logic              dq_oe_r, dq_oe_nxt_s;
  logic              ce_n_r, ce_n_nxt_s;
  logic              ce2_r, ce2_nxt_s;
  logic              oe_n_r, oe_n_nxt_s;
  logic              we_n_r, we_n_nxt_s;
  logic              lb_n_r, lb_n_nxt_s;
  logic              ub_n_r, ub_n_nxt_s;
  logic              gnt_a_r, gnt_a_nxt_s;
  logic              gnt_b_r, gnt_b_nxt_s;
  logic              rvalid_a_r, rvalid_a_nxt_s;
  logic              rvalid_b_r, rvalid_b_nxt_s;
  logic [DATA_W-1:0] rdata_r, rdata_nxt_s;
  logic              busy_r;

  // B wins only when A is absent or A was the last port served.
  logic              win_b_s;
  logic              win_we_s;
  logic [1:0]        win_be_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;

  assign win_b_s     = bus.req_b & (~bus.req_a | ~last_b_r);
  assign win_we_s    = win_b_s ? bus.we_b    : bus.we_a;
  assign win_be_s    = win_b_s ? bus.be_b    : bus.be_a;
  assign win_addr_s  = win_b_s ? bus.addr_b  : bus.addr_a;
  assign win_wdata_s = win_b_s ? bus.wdata_b : bus.wdata_a;

  // Next-state decode; pin values are those of the state being entered.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    last_b_nxt_s   = last_b_r;
    port_b_nxt_s   = port_b_r;
    we_nxt_s       = we_r;
    addr_nxt_s     = addr_r;
    dq_o_nxt_s     = dq_o_r;
    dq_oe_nxt_s    = dq_oe_r;
    ce_n_nxt_s     = ce_n_r;
    ce2_nxt_s      = ce2_r;
    oe_n_nxt_s     = oe_n_r;
    we_n_nxt_s     = we_n_r;
    lb_n_nxt_s     = lb_n_r;
    ub_n_nxt_s     = ub_n_r;
    gnt_a_nxt_s    = 1'b0;
    gnt_b_nxt_s    = 1'b0;
    rvalid_a_nxt_s = 1'b0;
    rvalid_b_nxt_s = 1'b0;
    rdata_nxt_s    = rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_a | bus.req_b) begin
          state_nxt_s  = ST_SETUP;
          port_b_nxt_s = win_b_s;
          last_b_nxt_s = win_b_s;
          we_nxt_s     = win_we_s;
          addr_nxt_s   = win_addr_s;
          dq_o_nxt_s   = win_we_s ? win_wdata_s : dq_o_r;
          dq_oe_nxt_s  = win_we_s;
          ce_n_nxt_s   = 1'b0;
          ce2_nxt_s    = 1'b1;
          lb_n_nxt_s   = win_we_s ? ~win_be_s[0] : 1'b0;
          ub_n_nxt_s   = win_we_s ? ~win_be_s[1] : 1'b0;
          cnt_nxt_s    = win_we_s ? WR_LAST : RD_LAST;
          gnt_a_nxt_s  = ~win_b_s;
          gnt_b_nxt_s  = win_b_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (we_r) begin
          state_nxt_s = ST_WR;
          we_n_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_RD;
          oe_n_nxt_s  = 1'b0;
        end
      end
      ST_RD: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s    = ST_HOLD;
          oe_n_nxt_s     = 1'b1;
          rdata_nxt_s    = sram_dq_i;
          rvalid_a_nxt_s = ~port_b_r;
          rvalid_b_nxt_s = port_b_r;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_WR: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_HOLD;
          we_n_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_HOLD: begin
        ce_n_nxt_s  = 1'b1;
        ce2_nxt_s   = 1'b0;
        lb_n_nxt_s  = 1'b1;
        ub_n_nxt_s  = 1'b1;
        dq_oe_nxt_s = 1'b0;
        if (TURN_EN) begin
          state_nxt_s = ST_TURN;
          cnt_nxt_s   = TURN_LAST;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_TURN: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ce_n_nxt_s  = 1'b1;
        ce2_nxt_s   = 1'b0;
        oe_n_nxt_s  = 1'b1;
        we_n_nxt_s  = 1'b1;
        lb_n_nxt_s  = 1'b1;
        ub_n_nxt_s  = 1'b1;
        dq_oe_nxt_s = 1'b0;
      end
    endcase
  end

  // State, transaction context and registered pin/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      last_b_r   <= 1'b1;
      port_b_r   <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      dq_o_r     <= '0;
      dq_oe_r    <= 1'b0;
      ce_n_r     <= 1'b1;
      ce2_r      <= 1'b0;
      oe_n_r     <= 1'b1;
      we_n_r     <= 1'b1;
      lb_n_r     <= 1'b1;
      ub_n_r     <= 1'b1;
      gnt_a_r    <= 1'b0;
      gnt_b_r    <= 1'b0;
      rvalid_a_r <= 1'b0;
      rvalid_b_r <= 1'b0;
      rdata_r    <= '0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      last_b_r   <= last_b_nxt_s;
      port_b_r   <= port_b_nxt_s;
      we_r       <= we_nxt_s;
      addr_r     <= addr_nxt_s;
      dq_o_r     <= dq_o_nxt_s;
      dq_oe_r    <= dq_oe_nxt_s;
      ce_n_r     <= ce_n_nxt_s;
      ce2_r      <= ce2_nxt_s;
      oe_n_r     <= oe_n_nxt_s;
      we_n_r     <= we_n_nxt_s;
      lb_n_r     <= lb_n_nxt_s;
      ub_n_r     <= ub_n_nxt_s;
      gnt_a_r    <= gnt_a_nxt_s;
      gnt_b_r    <= gnt_b_nxt_s;
      rvalid_a_r <= rvalid_a_nxt_s;
      rvalid_b_r <= rvalid_b_nxt_s;
      rdata_r    <= rdata_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
    end
  end

  assign sram_addr    = addr_r;
  assign sram_dq_o    = dq_o_r;
  assign sram_dq_oe   = dq_oe_r;
  assign sram_ce_n    = ce_n_r;
  assign sram_ce2     = ce2_r;
  assign sram_oe_n    = oe_n_r;
  assign sram_we_n    = we_n_r;
  assign sram_lb_n    = lb_n_r;
  assign sram_ub_n    = ub_n_r;
  assign bus.gnt_a    = gnt_a_r;
  assign bus.gnt_b    = gnt_b_r;
  assign bus.rvalid_a = rvalid_a_r;
  assign bus.rvalid_b = rvalid_b_r;
  assign bus.rdata    = rdata_r;
  assign bus.busy     = busy_r;
endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: two instances (default timing, and RD_WAIT=1/WR_WAIT=2/TURN=0)
// against a bench SRAM, a phase-arithmetic reference model and directed literal checks.
module tb_sram_arb_ctrl;
  localparam int AW = 22;
  localparam int DW = 16;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } rq_t;

  typedef struct packed {
    logic gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
    logic ce_n, ce2, oe_n, we_n, lb_n, ub_n, dq_oe;
    logic [AW-1:0] addr;
    logic [DW-1:0] dq_o;
    logic [DW-1:0] rdata;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rq_t           rq [2][2];
  obs_t          o [2];
  logic [AW-1:0] s_addr [2];
  logic [DW-1:0] s_dqo [2];
  logic [DW-1:0] s_dqi [2];
  logic          s_dq_oe [2], s_ce_n [2], s_oe_n [2], s_we_n [2], s_ce2 [2], s_lb_n [2], s_ub_n [2];

  int n_chk = 0;
  int n_fail = 0;

  sram_arb_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  sram_arb_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  assign bus0.req_a = rq[0][0].req;    assign bus0.req_b = rq[0][1].req;
  assign bus0.we_a = rq[0][0].we;      assign bus0.we_b = rq[0][1].we;
  assign bus0.be_a = rq[0][0].be;      assign bus0.be_b = rq[0][1].be;
  assign bus0.addr_a = rq[0][0].addr;  assign bus0.addr_b = rq[0][1].addr;
  assign bus0.wdata_a = rq[0][0].wdata; assign bus0.wdata_b = rq[0][1].wdata;
  assign bus1.req_a = rq[1][0].req;    assign bus1.req_b = rq[1][1].req;
  assign bus1.we_a = rq[1][0].we;      assign bus1.we_b = rq[1][1].we;
  assign bus1.be_a = rq[1][0].be;      assign bus1.be_b = rq[1][1].be;
  assign bus1.addr_a = rq[1][0].addr;  assign bus1.addr_b = rq[1][1].addr;
  assign bus1.wdata_a = rq[1][0].wdata; assign bus1.wdata_b = rq[1][1].wdata;

  assign o[0] = {bus0.gnt_a, bus0.gnt_b, bus0.rvalid_a, bus0.rvalid_b, bus0.busy,
                 s_ce_n[0], s_ce2[0], s_oe_n[0], s_we_n[0], s_lb_n[0], s_ub_n[0], s_dq_oe[0],
                 s_addr[0], s_dqo[0], bus0.rdata};
  assign o[1] = {bus1.gnt_a, bus1.gnt_b, bus1.rvalid_a, bus1.rvalid_b, bus1.busy,
                 s_ce_n[1], s_ce2[1], s_oe_n[1], s_we_n[1], s_lb_n[1], s_ub_n[1], s_dq_oe[1],
                 s_addr[1], s_dqo[1], bus1.rdata};

  sram_arb_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
    .sram_addr(s_addr[0]), .sram_dq_o(s_dqo[0]), .sram_dq_oe(s_dq_oe[0]), .sram_dq_i(s_dqi[0]),
    .sram_ce_n(s_ce_n[0]), .sram_oe_n(s_oe_n[0]), .sram_we_n(s_we_n[0]), .sram_ce2(s_ce2[0]),
    .sram_lb_n(s_lb_n[0]), .sram_ub_n(s_ub_n[0])
  );

  sram_arb_ctrl #(.RD_WAIT(1), .WR_WAIT(2), .TURN(0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .sram_addr(s_addr[1]), .sram_dq_o(s_dqo[1]), .sram_dq_oe(s_dq_oe[1]), .sram_dq_i(s_dqi[1]),
    .sram_ce_n(s_ce_n[1]), .sram_oe_n(s_oe_n[1]), .sram_we_n(s_we_n[1]), .sram_ce2(s_ce2[1]),
    .sram_lb_n(s_lb_n[1]), .sram_ub_n(s_ub_n[1])
  );

  // Timing configuration of each instance, as the bench understands it.
  function automatic int wt(int i, bit we);
    if (i == 0) return 3;
    return we ? 2 : 1;
  endfunction

  function automatic int tn(int i);
    return (i == 0) ? 3'd1 : 3'd0;
  endfunction

  function automatic int mkey(int i, logic [AW-1:0] a);
    return i * 4194304 + int'(a);
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw, logic [1:0] be);
    return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bench SRAM: writes lanes while CE and WE are active, returns data while OE is active.
  logic [DW-1:0] sram_mem [int];
  function automatic logic [DW-1:0] sram_rd(int key);
    return sram_mem.exists(key) ? sram_mem[key] : 16'h0000;
  endfunction

  initial begin
    s_dqi[0] = 16'h0000;
    s_dqi[1] = 16'h0000;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!s_ce_n[i] && s_ce2[i] && !s_we_n[i])
          sram_mem[mkey(i, s_addr[i])] = merge(sram_rd(mkey(i, s_addr[i])),
                                               s_dq_oe[i] ? s_dqo[i] : 16'hDEAD,
                                               ~{s_ub_n[i], s_lb_n[i]});
        s_dqi[i] = (!s_ce_n[i] && s_ce2[i] && !s_oe_n[i]) ? sram_rd(mkey(i, s_addr[i])) : 16'hBAD0;
      end
    end
  end

  // Reference model: access phase k (0 idle, 1 grant/setup, then strobe, hold, turnaround).
  logic [DW-1:0] mdl_mem [int];
  int            k [2] = '{0, 0};
  bit            lastb [2], pb [2], mwe [2];
  logic [1:0]    mbe [2];
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mwd [2], mrexp [2];

  function automatic logic [DW-1:0] mdl_rd(int key);
    return mdl_mem.exists(key) ? mdl_mem[key] : 16'h0000;
  endfunction

  function automatic int pick(int i);
    return (rq[i][1].req && (!rq[i][0].req || !lastb[i])) ? 1 : 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          k[i] = 0;
          lastb[i] = 1'b1;
        end else if (k[i] == 0) begin
          if (rq[i][0].req || rq[i][1].req) begin
            int p;
            p = pick(i);
            pb[i] = (p == 1);
            lastb[i] = (p == 1);
            mwe[i] = rq[i][p].we;
            mbe[i] = rq[i][p].be;
            maddr[i] = rq[i][p].addr;
            mwd[i] = rq[i][p].wdata;
            mrexp[i] = mdl_rd(mkey(i, rq[i][p].addr));
            if (rq[i][p].we)
              mdl_mem[mkey(i, rq[i][p].addr)] = merge(mrexp[i], rq[i][p].wdata, rq[i][p].be);
            k[i] = 1;
          end
        end else if (k[i] == 2 + wt(i, mwe[i]) + tn(i)) begin
          k[i] = 0;
        end else begin
          k[i] = k[i] + 1;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        obs_t e, m;
        int w;
        bit acc, st, rv;
        w   = wt(i, mwe[i]);
        acc = (k[i] >= 1) && (k[i] <= 2 + w);
        st  = (k[i] >= 2) && (k[i] <= 1 + w);
        rv  = !mwe[i] && (k[i] == 2 + w);
        e = '0;
        e.gnt_a = (k[i] == 1) && !pb[i];
        e.gnt_b = (k[i] == 1) && pb[i];
        e.rvalid_a = rv && !pb[i];
        e.rvalid_b = rv && pb[i];
        e.busy = (k[i] != 0);
        e.ce_n = !acc;
        e.ce2 = acc;
        e.oe_n = !(st && !mwe[i]);
        e.we_n = !(st && mwe[i]);
        e.lb_n = acc ? (mwe[i] ? !mbe[i][0] : 1'b0) : 1'b1;
        e.ub_n = acc ? (mwe[i] ? !mbe[i][1] : 1'b0) : 1'b1;
        e.dq_oe = acc && mwe[i];
        e.addr = maddr[i];
        e.dq_o = mwd[i];
        e.rdata = mrexp[i];
        m = '1;
        if (!acc) m.addr = '0;
        if (!(acc && mwe[i])) m.dq_o = '0;
        if (!rv) m.rdata = '0;
        chk($sformatf("cycle_u%0d_ph%0d", i, k[i]), 80'(o[i] & m), 80'(e & m));
      end
    end
  end

  // Drives one request and measures it in cycles counted from the IDLE cycle it was raised in.
  task automatic run(input int i, input int p, input bit we, input logic [1:0] be,
                     input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit rel_rst,
                     output int g_c, output int rv_c, output int end_c, output int we_lo,
                     output int oe_lo, output int lb_lo, output int ub_lo, output logic [DW-1:0] rd);
    g_c = -1; rv_c = -1; end_c = -1; we_lo = 0; oe_lo = 0; lb_lo = 0; ub_lo = 0; rd = '0;
    rq[i][p] = '{1'b1, we, be, a, wd};
    if (rel_rst) rst_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (((p == 0) ? o[i].gnt_a : o[i].gnt_b) && g_c < 0) begin
        g_c = c;
        rq[i][p].req = 1'b0;
      end
      if (!o[i].we_n && o[i].dq_oe) we_lo++;
      if (!o[i].oe_n) oe_lo++;
      if (!o[i].lb_n) lb_lo++;
      if (!o[i].ub_n) ub_lo++;
      if ((p == 0) ? o[i].rvalid_a : o[i].rvalid_b) begin
        rv_c = c;
        rd = o[i].rdata;
      end
      if (g_c > 0 && !o[i].busy) begin
        end_c = c;
        break;
      end
    end
    chk($sformatf("u%0d_access_completes", i), 80'(end_c > 0), 80'(1));
  endtask

  initial begin
    int g, rv, en, wl, ol, ll, ul, ev;
    int gc [8];
    int gp [8];
    int ng;
    logic [DW-1:0] rd;
    obs_t rs;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++)
        rq[i][p] = '0;

    // Reset held with a pending write request on port A.
    rq[0][0] = '{1'b1, 1'b1, 2'b11, 22'h000010, 16'h1234};
    repeat (3) @(negedge clk);
    rs = '0;
    rs.ce_n = 1'b1; rs.oe_n = 1'b1; rs.we_n = 1'b1; rs.lb_n = 1'b1; rs.ub_n = 1'b1;
    chk("reset_state_u0", 80'(o[0]), 80'(rs));
    chk("reset_state_u1", 80'(o[1]), 80'(rs));
    run(0, 0, 1'b1, 2'b11, 22'h000010, 16'h1234, 1'b1, g, rv, en, wl, ol, ll, ul, rd);
    chk("wr_gnt_cycle", 80'(g), 80'(1));
    chk("wr_we_low_cycles", 80'(wl), 80'(3));
    chk("wr_period", 80'(en), 80'(7));

    run(0, 0, 1'b0, 2'b00, 22'h000010, 16'h0000, 1'b0, g, rv, en, wl, ol, ll, ul, rd);
    chk("rd_rvalid_cycle", 80'(rv), 80'(5));
    chk("rd_data", 80'(rd), 80'(16'h1234));
    chk("rd_oe_low_cycles", 80'(ol), 80'(3));

    run(0, 0, 1'b1, 2'b01, 22'h000010, 16'hABCD, 1'b0, g, rv, en, wl, ol, ll, ul, rd);
    chk("bytewr_lb_cycles", 80'(ll), 80'(5));
    chk("bytewr_ub_cycles", 80'(ul), 80'(0));
    run(0, 0, 1'b0, 2'b00, 22'h000010, 16'h0000, 1'b0, g, rv, en, wl, ol, ll, ul, rd);
    chk("bytewr_readback", 80'(rd), 80'(16'h12CD));

    run(0, 1, 1'b1, 2'b11, 22'h000020, 16'h5A5A, 1'b0, g, rv, en, wl, ol, ll, ul, rd);
    chk("portb_wr_gnt", 80'(g), 80'(1));
    run(0, 1, 1'b0, 2'b00, 22'h000020, 16'h0000, 1'b0, g, rv, en, wl, ol, ll, ul, rd);
    chk("portb_rd_data", 80'(rd), 80'(16'h5A5A));
    chk("portb_rvalid_cycle", 80'(rv), 80'(5));

    // Both ports requesting continuously; B was served last.
    rq[0][0] = '{1'b1, 1'b0, 2'b11, 22'h000010, 16'h0000};
    rq[0][1] = '{1'b1, 1'b0, 2'b11, 22'h000020, 16'h0000};
    ng = 0;
    for (int c = 1; c <= 80 && ng < 8; c++) begin
      @(negedge clk);
      if (o[0].gnt_a || o[0].gnt_b) begin
        gc[ng] = c;
        gp[ng] = o[0].gnt_b ? 1 : 0;
        ng++;
      end
    end
    rq[0][0].req = 1'b0;
    rq[0][1].req = 1'b0;
    chk("rr_grant_count", 80'(ng), 80'(8));
    for (int j = 0; j < ng; j++) begin
      chk($sformatf("rr_order_%0d", j), 80'(gp[j]), 80'(j % 2));
      if (j > 0) chk($sformatf("rr_spacing_%0d", j), 80'(gc[j] - gc[j-1]), 80'(7));
    end
    for (int c = 0; c < 20 && o[0].busy; c++) @(negedge clk);

    // Reset while the write strobe is active.
    rq[0][0] = '{1'b1, 1'b1, 2'b11, 22'h000040, 16'h3333};
    ev = 0;
    for (int c = 0; c < 10 && ev == 0; c++) begin
      @(negedge clk);
      if (o[0].gnt_a) rq[0][0].req = 1'b0;
      if (!o[0].we_n) ev = 1;
    end
    chk("abort_reached_wr", 80'(ev), 80'(1));
    #2 rst_n = 1'b0;
    #1 chk("abort_strobes_released", 80'({o[0].we_n, o[0].ce_n, o[0].ce2, o[0].busy, o[0].dq_oe}),
           80'(5'b11000));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ev = 0;
    repeat (10) begin
      @(negedge clk);
      if (o[0].gnt_a || o[0].gnt_b || o[0].rvalid_a || o[0].rvalid_b || o[0].busy) ev++;
    end
    chk("abort_no_followup", 80'(ev), 80'(0));

    // Fast instance at the address extremes.
    run(1, 0, 1'b1, 2'b11, 22'h000000, 16'hBEEF, 1'b0, g, rv, en, wl, ol, ll, ul, rd);
    chk("u1_wr_period", 80'(en), 80'(5));
    chk("u1_wr_we_low", 80'(wl), 80'(2));
    run(1, 1, 1'b1, 2'b11, 22'h3FFFFF, 16'hC0DE, 1'b0, g, rv, en, wl, ol, ll, ul, rd);
    run(1, 0, 1'b0, 2'b00, 22'h000000, 16'h0000, 1'b0, g, rv, en, wl, ol, ll, ul, rd);
    chk("u1_rd_lo_data", 80'(rd), 80'(16'hBEEF));
    chk("u1_rd_rvalid_cycle", 80'(rv), 80'(3));
    chk("u1_rd_period", 80'(en), 80'(4));
    run(1, 1, 1'b0, 2'b00, 22'h3FFFFF, 16'h0000, 1'b0, g, rv, en, wl, ol, ll, ul, rd);
    chk("u1_rd_hi_data", 80'(rd), 80'(16'hC0DE));
    chk("u1_rd_hi_period", 80'(en), 80'(4));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench timeout");
  end
endmodule
